// File: rtl/seven_seg_mux_ctrl.sv
// Dual-digit seven-segment multiplexer: one shared hex decoder, fixed refresh
// schedule with blanking dead-time, digit values latched at slot entry.

module drive_seven_seg (
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  // Active-low segments ordered {g,f,e,d,c,b,a}
  always_comb begin
    seg_o = 7'b1111111;
    case (hex_i)
      4'h0: seg_o = 7'b1000000;
      4'h1: seg_o = 7'b1111001;
      4'h2: seg_o = 7'b0100100;
      4'h3: seg_o = 7'b0110000;
      4'h4: seg_o = 7'b0011001;
      4'h5: seg_o = 7'b0010010;
      4'h6: seg_o = 7'b0000010;
      4'h7: seg_o = 7'b1111000;
      4'h8: seg_o = 7'b0000000;
      4'h9: seg_o = 7'b0010000;
      4'hA: seg_o = 7'b0001000;
      4'hB: seg_o = 7'b0000011;
      4'hC: seg_o = 7'b1000110;
      4'hD: seg_o = 7'b0100001;
      4'hE: seg_o = 7'b0000110;
      4'hF: seg_o = 7'b0001110;
      default: seg_o = 7'b1111111;
    endcase
  end

endmodule

module seven_seg_mux_ctrl #(
  parameter int ON_CYCLES    = 24000,
  parameter int BLANK_CYCLES = 240
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  input  logic [1:0] digit_en,
  output logic [6:0] seven_seg,
  output logic [1:0] anode,
  output logic       slot
);

  localparam int MAX_CYCLES = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES);
  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {
    DIGIT0 = 2'd0,
    BLANK0 = 2'd1,
    DIGIT1 = 2'd2,
    BLANK1 = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [3:0]       val0_q, val0_d;
  logic [3:0]       val1_q, val1_d;
  logic             en0_q, en0_d;
  logic             en1_q, en1_d;
  logic             slot_q, slot_d;
  logic [1:0]       anode_q, anode_d;
  logic [6:0]       seg_q, seg_d;

  logic             slot_last;
  logic [3:0]       dec_hex;
  logic [6:0]       dec_seg;

  // Schedule sequencing and slot-entry latching
  always_comb begin
    state_d = state_q;
    count_d = count_q + CNT_W'(1);
    val0_d  = val0_q;
    val1_d  = val1_q;
    en0_d   = en0_q;
    en1_d   = en1_q;
    slot_d  = slot_q;

    if ((state_q == DIGIT0) || (state_q == DIGIT1)) begin
      slot_last = (count_q == ON_LAST);
    end else begin
      slot_last = (count_q == BLANK_LAST);
    end

    if (slot_last) begin
      count_d = '0;
      case (state_q)
        DIGIT0: state_d = BLANK0;
        BLANK0: begin
          state_d = DIGIT1;
          val1_d  = digit1;
          en1_d   = digit_en[1];
          slot_d  = 1'b1;
        end
        DIGIT1: state_d = BLANK1;
        BLANK1: begin
          state_d = DIGIT0;
          val0_d  = digit0;
          en0_d   = digit_en[0];
          slot_d  = 1'b0;
        end
        default: state_d = BLANK1;
      endcase
    end
  end

  // Outputs are derived from the next state so they switch on the transition edge
  assign dec_hex = (state_d == DIGIT1) ? val1_d : val0_d;

  drive_seven_seg u_decoder (
    .hex_i (dec_hex),
    .seg_o (dec_seg)
  );

  always_comb begin
    anode_d = 2'b11;
    seg_d   = 7'b1111111;
    case (state_d)
      DIGIT0: begin
        if (en0_d) begin
          anode_d = 2'b10;
          seg_d   = dec_seg;
        end
      end
      DIGIT1: begin
        if (en1_d) begin
          anode_d = 2'b01;
          seg_d   = dec_seg;
        end
      end
      default: begin
        anode_d = 2'b11;
        seg_d   = 7'b1111111;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BLANK1;
      count_q <= '0;
      val0_q  <= 4'h0;
      val1_q  <= 4'h0;
      en0_q   <= 1'b0;
      en1_q   <= 1'b0;
      slot_q  <= 1'b1;
      anode_q <= 2'b11;
      seg_q   <= 7'b1111111;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      val0_q  <= val0_d;
      val1_q  <= val1_d;
      en0_q   <= en0_d;
      en1_q   <= en1_d;
      slot_q  <= slot_d;
      anode_q <= anode_d;
      seg_q   <= seg_d;
    end
  end

  assign seven_seg = seg_q;
  assign anode     = anode_q;
  assign slot      = slot_q;

endmodule

// File: tb/tb_seven_seg_mux_ctrl.sv
// Directed vector table plus a randomized soak against an independent
// schedule/decode reference for seven_seg_mux_ctrl (ON=4, BLANK=2).

module tb_seven_seg_mux_ctrl;

  logic       clk;
  logic       reset;
  logic [3:0] digit0;
  logic [3:0] digit1;
  logic [1:0] digit_en;
  logic [6:0] seven_seg;
  logic [1:0] anode;
  logic       slot;

  int errors = 0;
  int checks = 0;

  seven_seg_mux_ctrl #(
    .ON_CYCLES    (4),
    .BLANK_CYCLES (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .digit0    (digit0),
    .digit1    (digit1),
    .digit_en  (digit_en),
    .seven_seg (seven_seg),
    .anode     (anode),
    .slot      (slot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] d0;
    logic [3:0] d1;
    logic [1:0] en;
    logic [1:0] exp_anode;
    logic [6:0] exp_seg;
    logic       exp_slot;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [6:0] ref_decode(input logic [3:0] h);
    case (h)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  task automatic add(input int n, input logic rst, input logic [3:0] d0, input logic [3:0] d1,
                     input logic [1:0] en, input logic [1:0] an, input logic [6:0] seg,
                     input logic sl);
    vec_t v;
    v.rst = rst; v.d0 = d0; v.d1 = d1; v.en = en;
    v.exp_anode = an; v.exp_seg = seg; v.exp_slot = sl;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, idx, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [3:0] lat0, lat1;
  logic       len0, len1;
  logic [1:0] e_an;
  logic [6:0] e_seg;
  logic       e_slot;
  int         p;

  initial begin
    reset    = 1'b1;
    digit0   = 4'h0;
    digit1   = 4'hA;
    digit_en = 2'b11;

    // rows: edges after reset release are counted n=1,2,...; DIGIT0 at n=2..5 (mod 12)
    add(3, 1'b1, 4'h0, 4'hA, 2'b11, 2'b11, 7'h7F, 1'b1);  // reset held
    add(1, 1'b0, 4'h0, 4'hA, 2'b11, 2'b11, 7'h7F, 1'b1);  // n1
    add(1, 1'b0, 4'h0, 4'hA, 2'b11, 2'b10, 7'h40, 1'b0);  // n2 start-up DIGIT0
    add(3, 1'b0, 4'h3, 4'hA, 2'b11, 2'b10, 7'h40, 1'b0);  // n3-5 change ignored
    add(2, 1'b0, 4'h3, 4'hA, 2'b11, 2'b11, 7'h7F, 1'b0);  // n6-7
    add(4, 1'b0, 4'h3, 4'hA, 2'b11, 2'b01, 7'h08, 1'b1);  // n8-11
    add(2, 1'b0, 4'h3, 4'hA, 2'b11, 2'b11, 7'h7F, 1'b1);  // n12-13
    add(1, 1'b0, 4'h3, 4'hA, 2'b11, 2'b10, 7'h30, 1'b0);  // n14
    add(3, 1'b0, 4'h8, 4'hA, 2'b11, 2'b10, 7'h30, 1'b0);  // n15-17 mid-slot change
    add(2, 1'b0, 4'h8, 4'hA, 2'b11, 2'b11, 7'h7F, 1'b0);  // n18-19
    add(4, 1'b0, 4'h8, 4'hA, 2'b11, 2'b01, 7'h08, 1'b1);  // n20-23
    add(2, 1'b0, 4'h8, 4'hA, 2'b01, 2'b11, 7'h7F, 1'b1);  // n24-25
    add(4, 1'b0, 4'h8, 4'hA, 2'b01, 2'b10, 7'h00, 1'b0);  // n26-29 new value shown
    add(2, 1'b0, 4'h8, 4'hA, 2'b01, 2'b11, 7'h7F, 1'b0);  // n30-31
    add(4, 1'b0, 4'h8, 4'hA, 2'b01, 2'b11, 7'h7F, 1'b1);  // n32-35 digit1 disabled
    add(2, 1'b0, 4'h8, 4'hA, 2'b11, 2'b11, 7'h7F, 1'b1);  // n36-37
    add(4, 1'b0, 4'h8, 4'hA, 2'b11, 2'b10, 7'h00, 1'b0);  // n38-41
    add(2, 1'b0, 4'h8, 4'hA, 2'b11, 2'b11, 7'h7F, 1'b0);  // n42-43
    add(2, 1'b0, 4'h8, 4'h5, 2'b11, 2'b01, 7'h12, 1'b1);  // n44-45 change on entry edge
    add(1, 1'b1, 4'h8, 4'h5, 2'b11, 2'b11, 7'h7F, 1'b1);  // n46 reset mid DIGIT1
    add(1, 1'b0, 4'h8, 4'h5, 2'b11, 2'b11, 7'h7F, 1'b1);  // m1
    add(2, 1'b0, 4'h8, 4'h5, 2'b11, 2'b10, 7'h00, 1'b0);  // m2-3 DIGIT0 resumes

    foreach (vecs[i]) begin
      reset    = vecs[i].rst;
      digit0   = vecs[i].d0;
      digit1   = vecs[i].d1;
      digit_en = vecs[i].en;
      step();
      chk("anode", i, {6'd0, anode}, {6'd0, vecs[i].exp_anode});
      chk("seven_seg", i, {1'b0, seven_seg}, {1'b0, vecs[i].exp_seg});
      chk("slot", i, {7'd0, slot}, {7'd0, vecs[i].exp_slot});
      $display("vec %0d: rst=%b d0=%h d1=%h en=%b -> anode=%b seg=%b slot=%b",
               i, vecs[i].rst, vecs[i].d0, vecs[i].d1, vecs[i].en, anode, seven_seg, slot);
    end

    // Soak: random inputs every cycle, checked against a schedule reference
    reset = 1'b1;
    step();
    reset = 1'b0;
    lat0 = 4'h0; lat1 = 4'h0; len0 = 1'b0; len1 = 1'b0;
    for (int n = 1; n <= 2000; n++) begin
      digit0   = 4'($urandom_range(0, 15));
      digit1   = 4'($urandom_range(0, 15));
      digit_en = 2'($urandom_range(0, 3));
      e_an = 2'b11; e_seg = 7'h7F; e_slot = 1'b1;
      if (n >= 2) begin
        p = (n - 2) % 12;
        if (p == 0) begin lat0 = digit0; len0 = digit_en[0]; end
        if (p == 6) begin lat1 = digit1; len1 = digit_en[1]; end
        e_slot = (p >= 6);
        if (p < 4 && len0) begin e_an = 2'b10; e_seg = ref_decode(lat0); end
        if (p >= 6 && p < 10 && len1) begin e_an = 2'b01; e_seg = ref_decode(lat1); end
      end
      step();
      chk("soak_anode", n, {6'd0, anode}, {6'd0, e_an});
      chk("soak_seg", n, {1'b0, seven_seg}, {1'b0, e_seg});
      chk("soak_slot", n, {7'd0, slot}, {7'd0, e_slot});
      checks++;
      if (anode == 2'b00 || (anode == 2'b11 && seven_seg != 7'h7F)) begin
        errors++;
        $display("FAIL soak_invariant[%0d]: anode=%b seg=%b, required anode!=00 and blank seg when anode=11",
                 n, anode, seven_seg);
      end
    end
    $display("soak: 2000 random cycles done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
